// File: rtl/sp_cpu_pkg.sv
// sp_cpu_pkg: opcodes, FSM state encoding and instruction field helpers for sp_cpu_core.
package sp_cpu_pkg;

    localparam int unsigned OPC_W       = 4;
    localparam int unsigned MAX_DATA_W  = 64;
    localparam int unsigned MAX_INSTR_W = MAX_DATA_W + OPC_W;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUBI = 4'h3;
    localparam logic [OPC_W-1:0] OP_ANDI = 4'h4;
    localparam logic [OPC_W-1:0] OP_ORI  = 4'h5;
    localparam logic [OPC_W-1:0] OP_XORI = 4'h6;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'h7;
    localparam logic [OPC_W-1:0] OP_LDR  = 4'h8;
    localparam logic [OPC_W-1:0] OP_ADDR = 4'h9;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hA;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'hB;
    localparam logic [OPC_W-1:0] OP_JC   = 4'hC;
    localparam logic [OPC_W-1:0] OP_OUT  = 4'hD;
    localparam logic [OPC_W-1:0] OP_MUL  = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_EXEC  = 2'd2;
    localparam state_t ST_HALT  = 2'd3;

    // Opcode sits directly above the data_w-bit immediate.
    function automatic logic [OPC_W-1:0] instr_op(input logic [MAX_INSTR_W-1:0] instr,
                                                  input int unsigned data_w);
        return OPC_W'(instr >> data_w);
    endfunction

    // Immediate is the low data_w bits of the word.
    function automatic logic [MAX_DATA_W-1:0] instr_imm(input logic [MAX_INSTR_W-1:0] instr,
                                                        input int unsigned data_w);
        logic [MAX_DATA_W-1:0] mask;
        mask = ~({MAX_DATA_W{1'b1}} << data_w);
        return MAX_DATA_W'(instr) & mask;
    endfunction

    // Register-file index k = imm[1:0].
    function automatic logic [1:0] reg_idx(input logic [MAX_DATA_W-1:0] imm);
        return imm[1:0];
    endfunction

endpackage

// File: rtl/sp_cpu_if.sv
// sp_cpu_if: control, program-load and observation bundle of sp_cpu_core.
interface sp_cpu_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = 4
);
    localparam int unsigned INSTR_W = 4 + DATA_W;

    logic               ena;
    logic               start;
    logic               prog_we;
    logic [AW-1:0]      prog_addr;
    logic [INSTR_W-1:0] prog_data;
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic [DATA_W-1:0]  acc_o;
    logic [AW-1:0]      pc_o;
    logic               busy;
    logic               halted;

    modport master (
        output ena, start, prog_we, prog_addr, prog_data,
        input  out_data, out_valid, acc_o, pc_o, busy, halted
    );

    modport slave (
        input  ena, start, prog_we, prog_addr, prog_data,
        output out_data, out_valid, acc_o, pc_o, busy, halted
    );
endinterface

// File: rtl/sp_cpu_alu.sv
// sp_cpu_alu: combinational accumulator ALU. Multiplier present only when SP_CPU_MUL_EN is defined.
module sp_cpu_alu
    import sp_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [OPC_W-1:0]  op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] opnd,
    output logic [DATA_W-1:0] result_c,
    output logic              carry_c,
    output logic              zero_c
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, acc} + {1'b0, opnd};
    assign diff = {1'b0, acc} - {1'b0, opnd};

    // Result and carry/borrow selection per opcode.
    always_comb begin
        result_c = acc;
        carry_c  = 1'b0;
        case (op)
            OP_LDI, OP_LDR: result_c = opnd;
            OP_ADDI, OP_ADDR: begin
                result_c = sum[DATA_W-1:0];
                carry_c  = sum[DATA_W];
            end
            OP_SUBI: begin
                result_c = diff[DATA_W-1:0];
                carry_c  = diff[DATA_W];
            end
            OP_ANDI: result_c = acc & opnd;
            OP_ORI:  result_c = acc | opnd;
            OP_XORI: result_c = acc ^ opnd;
`ifdef SP_CPU_MUL_EN
            OP_MUL:  result_c = acc * opnd;
`endif
            default: result_c = acc;
        endcase
        zero_c = (result_c == '0);
    end

endmodule

// File: rtl/sp_cpu_core.sv
// sp_cpu_core: two-cycle accumulator CPU with loadable instruction memory.
// Opcode E is MUL when SP_CPU_MUL_EN is defined, otherwise NOP.
module sp_cpu_core
    import sp_cpu_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IMEM_DEPTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    sp_cpu_if.slave  bus
);

    localparam int unsigned AW      = $clog2(IMEM_DEPTH);
    localparam int unsigned INSTR_W = 4 + DATA_W;

    state_t              state, state_nxt;
    logic [AW-1:0]       pc;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   acc;
    logic [DATA_W-1:0]   rf [4];
    logic                z_flag, c_flag;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q, busy_q, halted_q;
    logic [INSTR_W-1:0]  imem [IMEM_DEPTH];

    logic [OPC_W-1:0]    op;
    logic [DATA_W-1:0]   imm, opnd, alu_res;
    logic [1:0]          k;
    logic                alu_carry, alu_zero;
    logic                cmd_start, do_fetch, prog_wr;
    logic                wr_acc, wr_c, wr_rf, jump, out_fire;

    assign op   = instr_op(MAX_INSTR_W'(ir), DATA_W);
    assign imm  = DATA_W'(instr_imm(MAX_INSTR_W'(ir), DATA_W));
    assign k    = reg_idx(MAX_DATA_W'(imm));
    assign opnd = (op == OP_LDR || op == OP_ADDR || op == OP_MUL) ? rf[k] : imm;

    sp_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op       (op),
        .acc      (acc),
        .opnd     (opnd),
        .result_c (alu_res),
        .carry_c  (alu_carry),
        .zero_c   (alu_zero)
    );

    // Next state and per-cycle datapath controls.
    always_comb begin
        state_nxt = state;
        cmd_start = 1'b0;
        do_fetch  = 1'b0;
        prog_wr   = 1'b0;
        wr_acc    = 1'b0;
        wr_c      = 1'b0;
        wr_rf     = 1'b0;
        jump      = 1'b0;
        out_fire  = 1'b0;
        case (state)
            ST_IDLE, ST_HALT: begin
                prog_wr = bus.prog_we;
                if (bus.start) begin
                    state_nxt = ST_FETCH;
                    cmd_start = 1'b1;
                end
            end
            ST_FETCH: begin
                do_fetch  = 1'b1;
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                state_nxt = (op == OP_HLT) ? ST_HALT : ST_FETCH;
                case (op)
                    OP_LDI, OP_ANDI, OP_ORI, OP_XORI, OP_LDR: wr_acc = 1'b1;
                    OP_ADDI, OP_SUBI, OP_ADDR: begin
                        wr_acc = 1'b1;
                        wr_c   = 1'b1;
                    end
`ifdef SP_CPU_MUL_EN
                    OP_MUL: wr_acc = 1'b1;
`endif
                    OP_MOV:  wr_rf    = 1'b1;
                    OP_JMP:  jump     = 1'b1;
                    OP_JZ:   jump     = z_flag;
                    OP_JC:   jump     = c_flag;
                    OP_OUT:  out_fire = 1'b1;
                    default: ;
                endcase
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; frozen while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (bus.ena) begin
            state <= state_nxt;
        end
    end

    // Architectural registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            ir          <= '0;
            acc         <= '0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
            z_flag      <= 1'b0;
            c_flag      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else if (bus.ena) begin
            busy_q      <= (state_nxt == ST_FETCH) || (state_nxt == ST_EXEC);
            halted_q    <= (state_nxt == ST_HALT);
            out_valid_q <= out_fire;
            if (cmd_start) begin
                pc     <= '0;
                acc    <= '0;
                for (int i = 0; i < 4; i++) rf[i] <= '0;
                z_flag <= 1'b0;
                c_flag <= 1'b0;
            end
            if (do_fetch) begin
                ir <= imem[pc];
                pc <= AW'(pc + 1'b1);
            end
            if (wr_acc) begin
                acc    <= alu_res;
                z_flag <= alu_zero;
            end
            if (wr_c)     c_flag     <= alu_carry;
            if (wr_rf)    rf[k]      <= acc;
            if (jump)     pc         <= AW'(imm);
            if (out_fire) out_data_q <= acc;
        end
    end

    // Instruction memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.ena && prog_wr) begin
            imem[bus.prog_addr] <= bus.prog_data;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_o     = acc;
    assign bus.pc_o      = pc;
    assign bus.busy      = busy_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_sp_cpu_core.sv
// tb_sp_cpu_core: directed and random programs checked against an instruction-level model.
module tb_sp_cpu_core;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sp_cpu_if #(.DATA_W(DW), .AW(AW)) bus ();

    sp_cpu_core #(.DATA_W(DW), .IMEM_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] prog [DEPTH];
    int exp_cyc[$], exp_val[$], got_cyc[$], got_val[$];
    int exp_acc, exp_pc, exp_halt_edge, last_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ins(input int op, input int imm);
        return 12'((op << 8) | (imm & 255));
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) prog[i] = ins(0, 0);
    endtask

    // Instruction-level interpreter: instruction n executes on edge 2n+2 after start.
    task automatic model(input int steps, input int stall_at, input int stall_len);
        int acc, z, c, pc, op, imm, k, edge_n, res;
        int r [4];
        logic [11:0] ir;
        acc = 0; z = 0; c = 0; pc = 0;
        for (int i = 0; i < 4; i++) r[i] = 0;
        exp_cyc.delete();
        exp_val.delete();
        exp_halt_edge = -1;
        for (int n = 0; n <= steps && exp_halt_edge < 0; n++) begin
            ir  = prog[pc];
            op  = int'(ir[11:8]);
            imm = int'(ir[7:0]);
            k   = imm % 4;
            pc  = (pc + 1) % DEPTH;
            edge_n = 2 * n + 2;
            if (stall_len > 0 && edge_n > stall_at) edge_n += stall_len;
            res = -1;
            case (op)
                1:  res = imm;
                2:  begin res = acc + imm; c = (res > 255) ? 1 : 0; end
                3:  begin c = (acc < imm) ? 1 : 0; res = (acc - imm + 256) % 256; end
                4:  res = acc & imm;
                5:  res = acc | imm;
                6:  res = acc ^ imm;
                7:  r[k] = acc;
                8:  res = r[k];
                9:  begin res = acc + r[k]; c = (res > 255) ? 1 : 0; end
                10: pc = imm % DEPTH;
                11: if (z != 0) pc = imm % DEPTH;
                12: if (c != 0) pc = imm % DEPTH;
                13: begin exp_cyc.push_back(edge_n); exp_val.push_back(acc); last_out = acc; end
`ifdef SP_CPU_MUL_EN
                14: res = (acc * r[k]) % 256;
`endif
                15: exp_halt_edge = edge_n;
                default: ;
            endcase
            if (res >= 0) begin
                acc = res % 256;
                z = (acc == 0) ? 1 : 0;
            end
        end
        exp_acc = acc;
        exp_pc  = pc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.ena = 1'b1; bus.start = 1'b0; bus.prog_we = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_out = 0;
    endtask

    task automatic run_prog(input string name, input bit do_load, input int steps,
                            input int stall_at, input int stall_len, input bit poke);
        int t_end, halt_edge, n_cmp;
        if (do_load) begin
            do_reset();
            for (int a = 1; a < DEPTH; a++) begin
                bus.prog_we = 1'b1; bus.prog_addr = 4'(a); bus.prog_data = prog[a];
                @(negedge clk);
            end
            bus.prog_addr = 4'd0; bus.prog_data = prog[0];
        end
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.prog_we = 1'b0;
        got_cyc.delete();
        got_val.delete();
        halt_edge = -1;
        t_end = 2 * steps + 2 + stall_len;
        for (int e = 1; e <= t_end; e++) begin
            bus.ena = !(stall_len > 0 && e > stall_at && e <= stall_at + stall_len);
            if (poke && e >= 30 && e < 40) begin
                bus.prog_we = 1'b1; bus.prog_addr = 4'd2; bus.prog_data = ins(15, 0);
            end else begin
                bus.prog_we = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) begin
                got_cyc.push_back(e);
                got_val.push_back(int'(bus.out_data));
            end
            if (bus.halted && halt_edge < 0) halt_edge = e;
        end
        bus.ena = 1'b1; bus.prog_we = 1'b0;
        model(steps, stall_at, stall_len);
        check({name, "/out_count"}, 32'(got_cyc.size()), 32'(exp_cyc.size()));
        n_cmp = (got_cyc.size() < exp_cyc.size()) ? got_cyc.size() : exp_cyc.size();
        for (int i = 0; i < n_cmp; i++) begin
            check({name, "/out_edge"}, 32'(got_cyc[i]), 32'(exp_cyc[i]));
            check({name, "/out_data"}, 32'(got_val[i]), 32'(exp_val[i]));
        end
        check({name, "/halt_edge"}, 32'(halt_edge), 32'(exp_halt_edge));
        check({name, "/acc"}, 32'(bus.acc_o), 32'(exp_acc));
        check({name, "/pc"}, 32'(bus.pc_o), 32'(exp_pc));
        check({name, "/out_hold"}, 32'(bus.out_data), 32'(last_out));
    endtask

    initial begin
        bus.ena = 1'b1; bus.start = 1'b0; bus.prog_we = 1'b0;
        bus.prog_addr = '0; bus.prog_data = '0;
        last_out = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst/out_data",  32'(bus.out_data),  32'd0);
        check("rst/out_valid", 32'(bus.out_valid), 32'd0);
        check("rst/acc",       32'(bus.acc_o),     32'd0);
        check("rst/pc",        32'(bus.pc_o),      32'd0);
        check("rst/busy",      32'(bus.busy),      32'd0);
        check("rst/halted",    32'(bus.halted),    32'd0);
        rst_n = 1'b1;

        clear_prog();
        prog[0] = ins(1, 5); prog[1] = ins(2, 3); prog[2] = ins(13, 0); prog[3] = ins(15, 0);
        run_prog("basic", 1, 5, 0, 0, 0);

        clear_prog();
        prog[0] = ins(1, 8'hFF); prog[1] = ins(2, 1); prog[2] = ins(12, 4); prog[3] = ins(13, 0);
        prog[4] = ins(1, 8'hAA); prog[5] = ins(13, 0); prog[6] = ins(15, 0);
        run_prog("flags", 1, 10, 0, 0, 0);

        clear_prog();
        prog[0] = ins(1, 3);  prog[1] = ins(7, 0);  prog[2] = ins(8, 0);
        prog[3] = ins(3, 1);  prog[4] = ins(7, 0);  prog[5] = ins(11, 7);
        prog[6] = ins(10, 2); prog[7] = ins(13, 0); prog[8] = ins(15, 0);
        run_prog("loop", 1, 20, 0, 0, 0);

        // Restart from HALT, then reset partway through the loop.
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst/busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst/busy",   32'(bus.busy),   32'd0);
        check("midrst/halted", 32'(bus.halted), 32'd0);
        check("midrst/pc",     32'(bus.pc_o),   32'd0);
        check("midrst/acc",    32'(bus.acc_o),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_out = 0;
        run_prog("loop_rerun", 0, 20, 0, 0, 0);

        clear_prog();
        prog[0] = ins(2, 1); prog[1] = ins(13, 0);
        run_prog("wrap", 1, 40, 0, 0, 0);
        run_prog("wrap_ena", 1, 40, 10, 10, 1);

        clear_prog();
        prog[0] = ins(1, 6); prog[1] = ins(7, 0); prog[2] = ins(1, 7);
        prog[3] = ins(14, 0); prog[4] = ins(13, 0); prog[5] = ins(15, 0);
        run_prog("mul", 1, 8, 0, 0, 0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < DEPTH; i++)
                prog[i] = ins(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
            run_prog($sformatf("rand%0d", t), 1, 30, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
